// File: rtl/pdm_audio_tx.sv
// pdm_audio_tx: PCM-to-PDM playback path for the board audio amplifier.
// Signed PCM samples arrive over valid/ready into a one-deep holding register.
// They are promoted to the active register at each sample boundary and
// modulated by a first-order sigma-delta into a 1-bit stream.
//
//   state | meaning
//   IDLE  | muted: amp off, pdm low, accumulator/active/hold flushed
//   PRIME | amp on, modulating silence until the first buffered sample loads
//   RUN   | normal playback, underrun reporting armed
module pdm_audio_tx #(
  parameter int SAMPLE_W = 16,
  parameter int CLK_DIV  = 32,
  parameter int OSR      = 64
) (
  input  logic                i_clock,
  input  logic                i_reset,      // active-low, asynchronous
  input  logic                i_enable,
  input  logic [SAMPLE_W-1:0] i_pcm_data,
  input  logic                i_pcm_valid,
  output logic                o_pcm_ready,
  output logic                o_pdm_out,
  output logic                o_audio_en,
  output logic                o_underrun
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int BW = $clog2(OSR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TW-1:0]       r_tick_cnt;
  logic [BW-1:0]       r_bit_cnt;
  logic [SAMPLE_W-1:0] r_hold;
  logic                r_hold_full;
  logic [SAMPLE_W-1:0] r_active;
  logic [SAMPLE_W-1:0] r_acc;
  logic                r_pdm;

  logic                w_tick;
  logic                w_boundary;
  logic                w_accept;
  logic                w_load;
  logic                w_mod;
  logic [SAMPLE_W-1:0] w_u;
  logic [SAMPLE_W:0]   w_sum;

  assign w_tick     = (r_tick_cnt == TW'(CLK_DIV - 1));
  assign w_boundary = w_tick && (r_bit_cnt == BW'(OSR - 1));
  assign w_load     = w_boundary && r_hold_full;
  assign w_mod      = w_tick && (r_state != S_IDLE);

  // Offset-binary view of the active sample: 0x8000 -> 0, 0x7FFF -> full scale.
  assign w_u   = {~r_active[SAMPLE_W-1], r_active[SAMPLE_W-2:0]};
  assign w_sum = {1'b0, r_acc} + {1'b0, w_u};

  assign o_pcm_ready = i_enable && (r_state != S_IDLE) && !r_hold_full;
  assign w_accept    = i_pcm_valid && o_pcm_ready;
  assign o_audio_en  = (r_state != S_IDLE);
  // Boundary sees the pre-cycle hold_full, so a same-cycle accept still reports.
  assign o_underrun  = i_enable && (r_state == S_RUN) && w_boundary && !r_hold_full;
  assign o_pdm_out   = r_pdm;

  // Free-running bit and sample timing; only reset realigns it.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= (r_bit_cnt == BW'(OSR - 1)) ? '0 : r_bit_cnt + 1'b1;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; dropping enable always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (!i_enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_PRIME;
        S_PRIME: if (w_load) w_state_nxt = S_RUN;
        S_RUN:   w_state_nxt = S_RUN;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Sample buffering and sigma-delta modulator.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_active    <= '0;
      r_acc       <= '0;
      r_pdm       <= 1'b0;
    end else if (!i_enable || (r_state == S_IDLE)) begin
      r_hold_full <= 1'b0;
      r_active    <= '0;
      r_acc       <= '0;
      r_pdm       <= 1'b0;
    end else begin
      if (w_mod) begin
        {r_pdm, r_acc} <= w_sum;
      end
      if (w_boundary) begin
        if (r_hold_full) begin
          r_active    <= r_hold;
          r_hold_full <= 1'b0;
        end else begin
          r_active    <= '0;
        end
      end
      // Accept is only possible with hold empty, so it never races the load above.
      if (w_accept) begin
        r_hold      <= i_pcm_data;
        r_hold_full <= 1'b1;
      end
    end
  end

endmodule
